// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, instruction-type codes, constants and entry types
// for the ALU reservation station.
//   snoop(): resolves one operand against the two CDB broadcasts. It is used for
//   dispatch bypass and for wakeup. The ALU port wins when both tags match.
package alu_rs_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned ROB_IDX_W = 4;
   localparam int unsigned INSTY_W   = 6;

   localparam logic True  = 1'b1;
   localparam logic False = 1'b0;

   localparam logic [XLEN-1:0]      Null32 = '0;
   localparam logic [ROB_IDX_W-1:0] Null4  = '0;

   typedef enum logic [INSTY_W-1:0] {
      InstyAdd, InstySub, InstySll, InstySlt, InstySltu, InstyXor, InstySrl, InstySra,
      InstyOr, InstyAnd, InstyBeq, InstyBne, InstyBlt, InstyBge, InstyBltu, InstyBgeu,
      InstyJalr
   } insty_e;

   typedef struct packed {
      logic                 rdy;
      logic [XLEN-1:0]      val;
      logic [ROB_IDX_W-1:0] q;
   } operand_t;

   typedef struct packed {
      logic                 busy;
      logic [INSTY_W-1:0]   insty;
      operand_t             op1;
      operand_t             op2;
      logic [ROB_IDX_W-1:0] rob_idx;
   } rs_entry_t;

   typedef struct packed {
      logic                 flag;
      logic [ROB_IDX_W-1:0] idx;
      logic [XLEN-1:0]      val;
   } cdb_t;

   function automatic operand_t snoop(operand_t op, cdb_t alu, cdb_t lsb);
      operand_t res;
      res = op;
      if (!op.rdy) begin
         if (alu.flag && (op.q == alu.idx)) begin
            res.rdy = True;
            res.val = alu.val;
         end else if (lsb.flag && (op.q == lsb.idx)) begin
            res.rdy = True;
            res.val = lsb.val;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB-snoop and ALU-issue signals of the ALU reservation
// station.
//   master: dispatcher/CDB/ALU side (drives dispatch and CDB, sees issue + rs_full)
//   slave : the reservation station itself
interface alu_rs_if;
   import alu_rs_pkg::*;

   logic                 disp_flag;
   logic [INSTY_W-1:0]   disp_insty;
   logic                 disp_rdy1;
   logic                 disp_rdy2;
   logic [XLEN-1:0]      disp_v1;
   logic [XLEN-1:0]      disp_v2;
   logic [ROB_IDX_W-1:0] disp_q1;
   logic [ROB_IDX_W-1:0] disp_q2;
   logic [ROB_IDX_W-1:0] disp_rob_idx;
   logic                 rs_full;

   logic                 cdb_alu_flag;
   logic [ROB_IDX_W-1:0] cdb_alu_idx;
   logic [XLEN-1:0]      cdb_alu_val;
   logic                 cdb_lsb_flag;
   logic [ROB_IDX_W-1:0] cdb_lsb_idx;
   logic [XLEN-1:0]      cdb_lsb_val;

   logic                 ins_flag;
   logic [INSTY_W-1:0]   insty;
   logic [XLEN-1:0]      val1;
   logic [XLEN-1:0]      val2;
   logic [ROB_IDX_W-1:0] ROB_idx;

   modport master (
      output disp_flag, disp_insty, disp_rdy1, disp_rdy2, disp_v1, disp_v2, disp_q1, disp_q2,
             disp_rob_idx, cdb_alu_flag, cdb_alu_idx, cdb_alu_val, cdb_lsb_flag, cdb_lsb_idx,
             cdb_lsb_val,
      input  rs_full, ins_flag, insty, val1, val2, ROB_idx
   );

   modport slave (
      input  disp_flag, disp_insty, disp_rdy1, disp_rdy2, disp_v1, disp_v2, disp_q1, disp_q2,
             disp_rob_idx, cdb_alu_flag, cdb_alu_idx, cdb_alu_val, cdb_lsb_flag, cdb_lsb_idx,
             cdb_lsb_val,
      output rs_full, ins_flag, insty, val1, val2, ROB_idx
   );

endinterface

// File: rtl/alu_rs_select.sv
// alu_rs_select: N-wide request picker returning a valid bit and an index.
//   req   : request vector
//   age   : per-entry age (only with ALU_RS_AGE_PRIORITY_EN defined)
//   valid : some request set
//   idx   : chosen index; lowest index by default, or the largest age with
//           ties going to the lowest index when ALU_RS_AGE_PRIORITY_EN is defined
module alu_rs_select #(
   parameter int unsigned N = 8,
   localparam int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]            req,
`ifdef ALU_RS_AGE_PRIORITY_EN
   input  logic [N-1:0][IdxW-1:0]  age,
`endif
   output logic                    valid,
   output logic [IdxW-1:0]         idx
);

`ifdef ALU_RS_AGE_PRIORITY_EN
   logic [IdxW-1:0] best;
`endif

   always_comb begin
      valid = 1'b0;
      idx   = '0;
`ifdef ALU_RS_AGE_PRIORITY_EN
      best  = '0;
`endif
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i]) begin
`ifdef ALU_RS_AGE_PRIORITY_EN
            // strict compare keeps the lower index on equal age
            if (!valid || (age[i] > best)) begin
               valid = 1'b1;
               idx   = IdxW'(i);
               best  = age[i];
            end
`else
            if (!valid) begin
               valid = 1'b1;
               idx   = IdxW'(i);
            end
`endif
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
//   clk, rst (async, active-low), rdy (global run enable, low = stall),
//   jp_wrong (mispredict flush), bus (alu_rs_if.slave: dispatch, CDB snoop, issue).
// Optional macro ALU_RS_AGE_PRIORITY_EN: oldest-ready-first select via per-entry
// age counters; undefined selects the lowest-index ready entry.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int unsigned RS_SIZE = 8
) (
   input logic         clk,
   input logic         rst,
   input logic         rdy,
   input logic         jp_wrong,
   alu_rs_if.slave     bus
);

   localparam int unsigned IdxW = $clog2(RS_SIZE);

   rs_entry_t [RS_SIZE-1:0] ent_q, ent_d;
   rs_entry_t               new_ent;
   logic [RS_SIZE-1:0]      busy_vec, ready_vec;
   logic                    rs_full;
   logic                    sel_valid, free_valid;
   logic [IdxW-1:0]         sel_idx, free_idx;
   cdb_t                    cdb_alu, cdb_lsb;

   logic                    ins_flag_q, ins_flag_d;
   logic [INSTY_W-1:0]      insty_q, insty_d;
   logic [XLEN-1:0]         val1_q, val1_d, val2_q, val2_d;
   logic [ROB_IDX_W-1:0]    rob_idx_q, rob_idx_d;

`ifdef ALU_RS_AGE_PRIORITY_EN
   logic [RS_SIZE-1:0][IdxW-1:0] age_q, age_d;
`endif

   assign cdb_alu = '{flag: bus.cdb_alu_flag, idx: bus.cdb_alu_idx, val: bus.cdb_alu_val};
   assign cdb_lsb = '{flag: bus.cdb_lsb_flag, idx: bus.cdb_lsb_idx, val: bus.cdb_lsb_val};

   // Select only sees registered readiness; same-edge wakeups issue a cycle later.
   always_comb begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         busy_vec[i]  = ent_q[i].busy;
         ready_vec[i] = ent_q[i].busy & ent_q[i].op1.rdy & ent_q[i].op2.rdy;
      end
   end

   // Conservative: a slot freed by issue at this edge is not reusable until the next.
   assign rs_full     = &busy_vec;
   assign bus.rs_full = rs_full;

   alu_rs_select #(.N(RS_SIZE)) u_issue_sel (
      .req   (ready_vec),
`ifdef ALU_RS_AGE_PRIORITY_EN
      .age   (age_q),
`endif
      .valid (sel_valid),
      .idx   (sel_idx)
   );

   alu_rs_select #(.N(RS_SIZE)) u_free_sel (
      .req   (~busy_vec),
`ifdef ALU_RS_AGE_PRIORITY_EN
      .age   ('0),
`endif
      .valid (free_valid),
      .idx   (free_idx)
   );

   always_comb begin
      new_ent         = '0;
      new_ent.busy    = True;
      new_ent.insty   = bus.disp_insty;
      new_ent.op1     = snoop(operand_t'{bus.disp_rdy1, bus.disp_v1, bus.disp_q1}, cdb_alu, cdb_lsb);
      new_ent.op2     = snoop(operand_t'{bus.disp_rdy2, bus.disp_v2, bus.disp_q2}, cdb_alu, cdb_lsb);
      new_ent.rob_idx = bus.disp_rob_idx;
   end

   always_comb begin
      ent_d      = ent_q;
      ins_flag_d = ins_flag_q;
      insty_d    = insty_q;
      val1_d     = val1_q;
      val2_d     = val2_q;
      rob_idx_d  = rob_idx_q;
`ifdef ALU_RS_AGE_PRIORITY_EN
      age_d      = age_q;
`endif
      if (rdy) begin
         if (jp_wrong) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) ent_d[i].busy = False;
            ins_flag_d = False;
         end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
               if (ent_q[i].busy) begin
                  ent_d[i].op1 = snoop(ent_q[i].op1, cdb_alu, cdb_lsb);
                  ent_d[i].op2 = snoop(ent_q[i].op2, cdb_alu, cdb_lsb);
               end
            end
            if (sel_valid) begin
               ins_flag_d          = True;
               insty_d             = ent_q[sel_idx].insty;
               val1_d              = ent_q[sel_idx].op1.val;
               val2_d              = ent_q[sel_idx].op2.val;
               rob_idx_d           = ent_q[sel_idx].rob_idx;
               ent_d[sel_idx].busy = False;
            end else begin
               ins_flag_d = False;
            end
            // free_valid is exactly !rs_full
            if (bus.disp_flag && free_valid) begin
               ent_d[free_idx] = new_ent;
`ifdef ALU_RS_AGE_PRIORITY_EN
               for (int unsigned i = 0; i < RS_SIZE; i++) begin
                  if (ent_q[i].busy && (age_q[i] != '1)) age_d[i] = age_q[i] + 1'b1;
               end
               age_d[free_idx] = '0;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_q      <= '0;
         ins_flag_q <= False;
         insty_q    <= '0;
         val1_q     <= Null32;
         val2_q     <= Null32;
         rob_idx_q  <= Null4;
`ifdef ALU_RS_AGE_PRIORITY_EN
         age_q      <= '0;
`endif
      end else begin
         ent_q      <= ent_d;
         ins_flag_q <= ins_flag_d;
         insty_q    <= insty_d;
         val1_q     <= val1_d;
         val2_q     <= val2_d;
         rob_idx_q  <= rob_idx_d;
`ifdef ALU_RS_AGE_PRIORITY_EN
         age_q      <= age_d;
`endif
      end
   end

   assign bus.ins_flag = ins_flag_q;
   assign bus.insty    = insty_q;
   assign bus.val1     = val1_q;
   assign bus.val2     = val2_q;
   assign bus.ROB_idx  = rob_idx_q;

   // Dispatching into a full station is a protocol violation; the op is dropped.
   disp_when_full: assert property (@(posedge clk) disable iff (!rst)
                                    !(rdy && bus.disp_flag && rs_full))
      else $warning("alu_rs: dispatch while rs_full dropped");

endmodule
